// File: rtl/rst_sync_seq.sv
// Reset synchronizer and sequencer: async assert, synchronized release,
// then a stretch and a channel-by-channel release in index order.
module rst_sync_seq #(
   parameter int NUM_STAGES = 2,
   parameter int NUM_CH     = 4,
   parameter int STRETCH    = 8,
   parameter int GAP        = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SW_RST_REQ,
   output logic [NUM_CH-1:0] SYNC_RST,
   output logic              RST_DONE
);

   localparam int IW = $clog2(NUM_CH) + 1;
   localparam logic [7:0]    S_LOAD = 8'(STRETCH - 1);
   localparam logic [7:0]    G_LOAD = 8'(GAP - 1);
   localparam logic [IW-1:0] LAST   = IW'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_STRETCH,
      ST_RELEASE,
      ST_RUN
   } state_t;

   logic [NUM_STAGES-1:0] chain;
   logic                  sync_ok;

   state_t            state, state_n;
   logic [7:0]        cnt, cnt_n;
   logic [IW-1:0]     idx, idx_n;
   logic [NUM_CH-1:0] rst_nx;
   logic              done_nx;
   logic              rel;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         chain <= '0;
      end else begin
         chain <= {chain[NUM_STAGES-2:0], 1'b1};
      end
   end

   assign sync_ok = chain[NUM_STAGES-1];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= ST_ASSERT;
         cnt      <= '0;
         idx      <= '0;
         SYNC_RST <= '0;
         RST_DONE <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         SYNC_RST <= rst_nx;
         RST_DONE <= done_nx;
      end
   end

   // The ASSERT exit edge already counts as the first stretch cycle.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      rst_nx  = SYNC_RST;
      done_nx = RST_DONE;
      rel     = 1'b0;
      unique case (state)
         ST_ASSERT: begin
            if (sync_ok) begin
               if (S_LOAD == 8'd0) begin
                  rel = 1'b1;
               end else begin
                  state_n = ST_STRETCH;
                  cnt_n   = S_LOAD - 8'd1;
               end
            end
         end
         ST_STRETCH, ST_RELEASE: begin
            if (cnt == 8'd0) begin
               rel = 1'b1;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         ST_RUN: begin
         end
         default: begin
            state_n = ST_ASSERT;
         end
      endcase

      if (rel) begin
         rst_nx = (SYNC_RST << 1) | NUM_CH'(1);
         if (idx == LAST) begin
            done_nx = 1'b1;
            state_n = ST_RUN;
         end else begin
            state_n = ST_RELEASE;
            idx_n   = idx + 1'b1;
            cnt_n   = G_LOAD;
         end
      end

      // A software request overrides any release due on the same edge.
      if (SW_RST_REQ && state != ST_ASSERT) begin
         rst_nx  = '0;
         done_nx = 1'b0;
         state_n = ST_STRETCH;
         cnt_n   = S_LOAD;
         idx_n   = '0;
      end
   end

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: release times derived from edge counts
// since the last reset or honoured software request.
module tb_rst_sync_seq;

   localparam int N  = 4;
   localparam int CH = 4;
   localparam int S  = 8;
   localparam int G  = 4;

   localparam int N2 = 2;
   localparam int S2 = 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          SW_RST_REQ = 1'b0;
   logic [CH-1:0] SYNC_RST;
   logic          RST_DONE;
   logic [0:0]    c_rst;
   logic          c_done;

   int checks = 0;
   int errors = 0;
   int k      = 0;
   int base   = N + S;

   rst_sync_seq #(
      .NUM_STAGES(N),
      .NUM_CH(CH),
      .STRETCH(S),
      .GAP(G)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .SW_RST_REQ(SW_RST_REQ),
      .SYNC_RST(SYNC_RST),
      .RST_DONE(RST_DONE)
   );

   rst_sync_seq #(
      .NUM_STAGES(N2),
      .NUM_CH(1),
      .STRETCH(S2),
      .GAP(1)
   ) dut_c (
      .CLK(CLK),
      .RST(RST),
      .SW_RST_REQ(1'b0),
      .SYNC_RST(c_rst),
      .RST_DONE(c_done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t k=%0d got %0h exp %0h",
                  tag, $time, k, got, exp);
      end
   endtask

   function automatic logic [CH-1:0] exp_rst(input int kk, input int bb);
      logic [CH-1:0] v;
      for (int i = 0; i < CH; i++) v[i] = (kk >= bb + i * G);
      return v;
   endfunction

   task automatic compare();
      chk("sync_rst", 32'(SYNC_RST), 32'(exp_rst(k, base)));
      chk("rst_done", 32'(RST_DONE), 32'(k >= base + (CH - 1) * G));
      chk("c_rst", 32'(c_rst), 32'(k >= N2 + S2));
      chk("c_done", 32'(c_done), 32'(k >= N2 + S2));
   endtask

   // One clock edge with an optional software pulse sampled on it.
   task automatic tick(input bit sw);
      SW_RST_REQ = sw;
      @(posedge CLK);
      k++;
      if (sw && k >= N + 2) base = k + S;
      #1;
      SW_RST_REQ = 1'b0;
      compare();
   endtask

   // Short RST low pulse between edges; outputs must clear with no edge.
   task automatic glitch();
      #2 RST = 1'b0;
      #1;
      chk("glitch_rst", 32'(SYNC_RST), 32'(0));
      chk("glitch_done", 32'(RST_DONE), 32'(0));
      chk("glitch_c", 32'({c_rst, c_done}), 32'(0));
      #2 RST = 1'b1;
      k    = 0;
      base = N + S;
   endtask

   int e0;

   initial begin
      #12 RST = 1'b0;
      #1;
      chk("async_rst", 32'(SYNC_RST), 32'(0));
      chk("async_done", 32'(RST_DONE), 32'(0));
      chk("async_c", 32'({c_rst, c_done}), 32'(0));
      #9 RST = 1'b1;

      // Request at edge 2 falls in ASSERT and must be ignored.
      while (k < 28) tick(k == 1);
      tick(1'b1);
      chk("sw_clear", 32'({SYNC_RST, RST_DONE}), 32'(0));
      while (k < 52) tick(1'b0);

      // Request landing on the edge that would release bit 2.
      tick(1'b1);
      e0 = k;
      while (k < e0 + S + 2 * G - 1) tick(1'b0);
      tick(1'b1);
      chk("mid_req", 32'(SYNC_RST), 32'(0));
      while (k < e0 + S + 2 * G + S + 1) tick(1'b0);

      // Glitch while bits 0-1 are released.
      while (k < base + G) tick(1'b0);
      chk("pre_glitch", 32'(SYNC_RST), 32'(4'b0011));
      glitch();
      while (k < N + S + CH * G) tick(1'b0);

      for (int n = 0; n < 800; n++) begin
         tick($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 199) == 0) glitch();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rst_sync_seq.md
# rst_sync_seq

Parametrised, multi-channel reset synchronizer and sequencer. It asserts a vector of active-low synchronous resets asynchronously from one external reset, and de-asserts them synchronously through a NUM_STAGES flop chain. After de-assertion it applies a minimum-hold stretch, then releases the channels one at a time in index order with a programmable gap. A software reset request re-runs the same sequence without an external reset. The block sits at the top of each clock domain and feeds the per-subsystem resets.

## Interface
- NUM_STAGES, 2: synchronizer depth (legal 2..8).
- NUM_CH, 4: number of reset output channels (legal 1..16).
- STRETCH, 8: cycles from synchronized de-assertion to release of channel 0 (legal 1..255).
- GAP, 4: cycles between consecutive channel releases (legal 1..255).

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  external reset; asynchronous, active-low.
- SW_RST_REQ  in  1  synchronous software reset request; single-cycle pulse, active-high.
- SYNC_RST  out  NUM_CH  per-channel reset, active-low; bit i is released i-th.
- RST_DONE  out  1  high when all channels are released.

## Operation
- All outputs and state are flops with async clear on RST low. Reset values: SYNC_RST = all 0, RST_DONE = 0, sync chain = 0, FSM = ASSERT, counters = 0.
- Sync chain: NUM_STAGES flops. Flop 0 D input is tied to 1. The chain is async-cleared by RST. Its output is sync_ok.
- FSM states:
  - ASSERT: hold all outputs low. When sync_ok = 1, go to STRETCH and load the counter.
  - STRETCH: count STRETCH cycles, then release SYNC_RST[0] and go to RELEASE with channel index 1.
  - RELEASE: every GAP cycles, release the next channel. The edge that releases channel NUM_CH-1 also sets RST_DONE and enters RUN.
  - RUN: hold. If NUM_CH = 1, RST_DONE rises on the same edge as SYNC_RST[0] and RELEASE is skipped.
- Released channels stay released. SYNC_RST is thermometer-coded and is only ever filled from bit 0 upward.
- SW_RST_REQ sampled high with RST high, in any state other than ASSERT:
  - On that edge, all SYNC_RST go 0 and RST_DONE goes 0.
  - FSM enters STRETCH with the counter reloaded.
  - The sync chain is untouched.
- SW_RST_REQ in ASSERT is ignored.
- SW_RST_REQ on the same edge as a scheduled release: the request wins, so no channel is released on that edge.
- RST low at any time, including mid-sequence or in the same cycle as SW_RST_REQ: all outputs go low immediately (async), with no dependency on CLK. The sequence restarts from ASSERT.
- Counter width is 8 bits. Channel index width is clog2(NUM_CH)+1. No wrap is possible within the legal ranges.

## Timing
- Assertion is combinationally asynchronous: SYNC_RST and RST_DONE go 0 within one flop clear delay of RST falling.
- Let edge 1 be the first CLK rising edge after RST rises, with setup met.
  - sync_ok rises at edge NUM_STAGES.
  - SYNC_RST[0] rises at edge NUM_STAGES+STRETCH.
  - SYNC_RST[i] rises at edge NUM_STAGES+STRETCH+i·GAP.
  - RST_DONE rises together with SYNC_RST[NUM_CH-1].
- For SW_RST_REQ sampled at edge E:
  - Outputs go 0 at edge E.
  - SYNC_RST[i] rises at edge E+STRETCH+i·GAP.
- All output changes other than async clear occur only on CLK rising edges.

## Test plan
Common setup: NUM_STAGES=4, NUM_CH=4, STRETCH=8, GAP=4, CLK period 10 with rising edges at 5, 15, 25, …; RST low 12–22.
- Async assertion: at t=13, SYNC_RST=4'b0000 and RST_DONE=0, with no CLK edge since RST fell.
- De-assertion and sequencing (edge k at 15+10k):
  - SYNC_RST[0]=0 at t=134 and 1 at t=136.
  - Bit 1 rises at 175, bit 2 at 215, bit 3 at 255.
  - RST_DONE=0 at 254 and 1 at 256.
- Software reset: pulse SW_RST_REQ over the edge at t=305.
  - SYNC_RST=0000 and RST_DONE=0 at t=306.
  - Bit 0 rises at 385, bits 1–3 at 425/465/505, RST_DONE at 505.
- Request mid-sequence: pulse SW_RST_REQ at the edge where bit 2 would rise. Bits 0 and 1 go back to 0 and bit 2 stays 0. Bit 0 re-rises 8 edges later.
- RST glitch mid-sequence: a 3 ns RST low pulse while bits 0–1 are released clears all outputs immediately. The full NUM_STAGES+STRETCH latency is then re-observed.
- Corner parameters: with NUM_CH=1, STRETCH=1, NUM_STAGES=2, SYNC_RST[0] and RST_DONE rise together at edge 3.
